// File: rtl/nibble_packer_pkg.sv
// Shared constants, state type and slot-placement helpers for the nibble packer.
// Optional flush support is controlled by the NIBBLE_PACKER_FLUSH_EN macro.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    LAST    = 1'b1
  } pack_state_e;

  function automatic int fill_width(input int num_nibbles);
    return $clog2(num_nibbles + 1);
  endfunction

  // Bit offset of nibble k within a word of num_nibbles nibbles.
  function automatic int slot_lsb(input int k, input int num_nibbles, input bit high_first);
    return high_first ? NIBBLE_W * (num_nibbles - 1 - k) : NIBBLE_W * k;
  endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble-in / word-out handshake bundle for the nibble packer.
// Carries in_flush only when NIBBLE_PACKER_FLUSH_EN is defined.
interface nibble_packer_if #(
  parameter int NUM_NIBBLES = 2
);
  import nibble_pkg::*;

  localparam int W  = NIBBLE_W * NUM_NIBBLES;
  localparam int FW = fill_width(NUM_NIBBLES);

  logic [NIBBLE_W-1:0] in_nibble;
  logic                in_valid;
  logic                in_ready;
`ifdef NIBBLE_PACKER_FLUSH_EN
  logic                in_flush;
`endif
  logic [W-1:0]        out_data;
  logic                out_valid;
  logic                out_ready;
  logic [FW-1:0]       fill_level;

`ifdef NIBBLE_PACKER_FLUSH_EN
  modport master (
    output in_nibble, in_valid, in_flush, out_ready,
    input  in_ready, out_data, out_valid, fill_level
  );
  modport slave (
    input  in_nibble, in_valid, in_flush, out_ready,
    output in_ready, out_data, out_valid, fill_level
  );
`else
  modport master (
    output in_nibble, in_valid, out_ready,
    input  in_ready, out_data, out_valid, fill_level
  );
  modport slave (
    input  in_nibble, in_valid, out_ready,
    output in_ready, out_data, out_valid, fill_level
  );
`endif

endinterface

// File: rtl/nibble_packer_out_reg.sv
// One-entry valid/ready holding register for completed words.
module nibble_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] word,
  input  logic         load,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // A load wins over a drain so back-to-back words never leave a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// Assembles a stream of nibbles into NUM_NIBBLES*4-bit words with one buffered output word.
// Define NIBBLE_PACKER_FLUSH_EN to add in_flush for early, zero-padded word completion.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int NUM_NIBBLES = 2,
  parameter bit HIGH_FIRST  = 1'b1
) (
  input logic      clk,
  input logic      rst,
  nibble_packer_if.slave bus
);

  localparam int W  = NIBBLE_W * NUM_NIBBLES;
  localparam int FW = fill_width(NUM_NIBBLES);
  localparam logic [FW-1:0] LAST_FILL = FW'(NUM_NIBBLES - 1);

  pack_state_e   state, state_next;
  logic [FW-1:0] fill, fill_next;
  logic [W-1:0]  acc, acc_next;
  logic [W-1:0]  slot_word, word, out_data;
  logic          flush, take, complete, out_valid;

`ifdef NIBBLE_PACKER_FLUSH_EN
  assign flush = bus.in_flush;
`else
  assign flush = 1'b0;
`endif

  // Only a finishing nibble can be blocked, and only by a full, undrained output register.
  assign bus.in_ready   = !((state == LAST || flush) && out_valid && !bus.out_ready);
  assign take           = bus.in_valid && bus.in_ready;
  assign complete       = take && (state == LAST || flush);
  assign word           = acc | slot_word;
  assign bus.fill_level = fill;
  assign bus.out_data   = out_data;
  assign bus.out_valid  = out_valid;

  always_comb begin
    slot_word = '0;
    for (int k = 0; k < NUM_NIBBLES; k++) begin
      if (take && fill == FW'(k)) begin
        slot_word[slot_lsb(k, NUM_NIBBLES, HIGH_FIRST) +: NIBBLE_W] = bus.in_nibble;
      end
    end
  end

  always_comb begin
    state_next = state;
    fill_next  = fill;
    acc_next   = acc;
    if (take) begin
      if (complete) begin
        fill_next = '0;
        acc_next  = '0;
      end else begin
        fill_next = fill + FW'(1);
        acc_next  = word;
      end
      state_next = (fill_next == LAST_FILL) ? LAST : COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      fill  <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
      acc   <= acc_next;
    end
  end

  nibble_out_reg #(
    .W(W)
  ) out_reg (
    .clk      (clk),
    .rst      (rst),
    .word     (word),
    .load     (complete),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(bus.out_ready)
  );

endmodule
